// File: rtl/umt_pkg.sv
// Shared types and constants for the UMT-to-PMT mapper: FSM states, error codes,
// default PMT geometry and the config/allocation table entry layouts.
package umt_pkg;

  localparam int NUM_UMTS          = 8;
  localparam int DEF_PMT_W_LOG2    = 6;
  localparam int DEF_PMT_D_LOG2    = 9;
  localparam int DEF_NUM_SRAM_PMTS = 64;
  localparam int DEF_NUM_TCAM_PMTS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SRAM_OVF = 2'd1;
  localparam logic [1:0] ERR_TCAM_OVF = 2'd2;
  localparam logic [1:0] ERR_CFG_DROP = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        ttype;
    logic [15:0] width;
    logic [15:0] depth;
  } cfg_entry_t;

  typedef struct packed {
    logic        valid;
    logic        ttype;
    logic [7:0]  base;
    logic [15:0] num;
  } alloc_entry_t;

endpackage

// File: rtl/umt_lmt_mapper_if.sv
// Config/trigger bus from the CSR block, mapping status back to it, and the
// allocation lookup port. The CSR side is master, the mapper is slave.
interface umt_lmt_mapper_if;
  import umt_pkg::*;

  logic        umt_cfg_valid;
  logic        umt_cfg_wr_en;
  logic [2:0]  umt_cfg_id;
  logic [15:0] umt_cfg_width;
  logic [15:0] umt_cfg_depth;
  logic        umt_cfg_type;
  logic        umt_map_trigger;

  logic        map_busy;
  logic        map_done;
  logic        map_error;
  logic [1:0]  map_err_code;
  logic [7:0]  total_lmts_used;
  logic [15:0] total_pmts_needed;

  logic [2:0]  lkp_id;
  logic        lkp_valid;
  logic        lkp_type;
  logic [7:0]  lkp_base;
  logic [15:0] lkp_num;

  state_t      dbg_state;

  // A config beat is a single-cycle strobe (valid & wr_en); there is no ready,
  // the mapper accepts in IDLE and drops (with a sticky flag) otherwise.
  modport master (
    output umt_cfg_valid, umt_cfg_wr_en, umt_cfg_id, umt_cfg_width,
           umt_cfg_depth, umt_cfg_type, umt_map_trigger, lkp_id,
    input  map_busy, map_done, map_error, map_err_code, total_lmts_used,
           total_pmts_needed, lkp_valid, lkp_type, lkp_base, lkp_num, dbg_state
  );

  modport slave (
    input  umt_cfg_valid, umt_cfg_wr_en, umt_cfg_id, umt_cfg_width,
           umt_cfg_depth, umt_cfg_type, umt_map_trigger, lkp_id,
    output map_busy, map_done, map_error, map_err_code, total_lmts_used,
           total_pmts_needed, lkp_valid, lkp_type, lkp_base, lkp_num, dbg_state
  );
endinterface

// File: rtl/umt_pmt_calc.sv
// Combinational PMT sizing: ceil-divide width/depth into PMT columns/rows, and
// multiply the parent's registered cols/rows into a 16-bit clamped PMT count.
module umt_pmt_calc #(
  parameter int PMT_W_LOG2 = 6,
  parameter int PMT_D_LOG2 = 9
) (
  input  logic [15:0] width,
  input  logic [15:0] depth,
  output logic [16:0] cols,
  output logic [16:0] rows,
  input  logic [16:0] cols_q,
  input  logic [16:0] rows_q,
  output logic [15:0] num
);
  localparam logic [16:0] W_PAD = 17'((1 << PMT_W_LOG2) - 1);
  localparam logic [16:0] D_PAD = 17'((1 << PMT_D_LOG2) - 1);

  logic [33:0] prod;

  always_comb begin
    cols = ({1'b0, width} + W_PAD) >> PMT_W_LOG2;
    rows = ({1'b0, depth} + D_PAD) >> PMT_D_LOG2;
    prod = {17'd0, cols_q} * {17'd0, rows_q};
    num  = (|prod[33:16]) ? 16'hFFFF : prod[15:0];
  end
endmodule

// File: rtl/umt_lmt_mapper.sv
// Holds 8 UMT configs and, on trigger, sizes each one in PMTs and allocates
// them first-fit from the SRAM or TCAM pool; results are readable per UMT.
module umt_lmt_mapper
  import umt_pkg::*;
#(
  parameter int PMT_W_LOG2    = DEF_PMT_W_LOG2,
  parameter int PMT_D_LOG2    = DEF_PMT_D_LOG2,
  parameter int NUM_SRAM_PMTS = DEF_NUM_SRAM_PMTS,
  parameter int NUM_TCAM_PMTS = DEF_NUM_TCAM_PMTS
) (
  input logic               clk,
  input logic               rst_n,
  umt_lmt_mapper_if.slave   bus
);
  state_t       state_q, state_d;
  logic [2:0]   idx_q;
  cfg_entry_t   cfg_q   [NUM_UMTS];
  alloc_entry_t alloc_q [NUM_UMTS];
  logic [16:0]  cols_q, rows_q;
  logic [7:0]   pool_used_q [2];
  logic [7:0]   lmts_q;
  logic [15:0]  pmts_q;
  logic         drop_q, sram_ovf_q, tcam_ovf_q;
  logic         busy_q, done_q, error_q;
  logic [1:0]   code_q;
  logic [7:0]   total_lmts_q;
  logic [15:0]  total_pmts_q;
  alloc_entry_t lkp_q;

  logic         cfg_wr, idle;
  cfg_entry_t   cur_cfg;
  logic [16:0]  calc_cols, calc_rows, pool_size, pmts_sum;
  logic [15:0]  calc_num, pmts_next;
  logic         fit, drop_now;
  logic [1:0]   code_next;

  assign cfg_wr = bus.umt_cfg_valid & bus.umt_cfg_wr_en;
  assign idle   = (state_q == ST_IDLE);

  umt_pmt_calc #(.PMT_W_LOG2(PMT_W_LOG2), .PMT_D_LOG2(PMT_D_LOG2)) u_calc (
    .width  (cur_cfg.width),
    .depth  (cur_cfg.depth),
    .cols   (calc_cols),
    .rows   (calc_rows),
    .cols_q (cols_q),
    .rows_q (rows_q),
    .num    (calc_num)
  );

  always_comb begin
    cur_cfg   = cfg_q[idx_q];
    pool_size = cur_cfg.ttype ? 17'(NUM_TCAM_PMTS) : 17'(NUM_SRAM_PMTS);
    fit       = ({9'd0, pool_used_q[cur_cfg.ttype]} + {1'b0, calc_num}) <= pool_size;
    pmts_sum  = {1'b0, pmts_q} + {1'b0, calc_num};
    pmts_next = pmts_sum[16] ? 16'hFFFF : pmts_sum[15:0];
    // A write landing in the FIN cycle itself is still a drop for this scan.
    drop_now  = drop_q | cfg_wr;
    if (drop_now)        code_next = ERR_CFG_DROP;
    else if (sram_ovf_q) code_next = ERR_SRAM_OVF;
    else if (tcam_ovf_q) code_next = ERR_TCAM_OVF;
    else                 code_next = ERR_NONE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.umt_map_trigger) state_d = ST_CALC;
      ST_CALC:  if (cur_cfg.valid)       state_d = ST_ACCUM;
                else if (idx_q == 3'd7)  state_d = ST_FIN;
      ST_ACCUM: state_d = (idx_q == 3'd7) ? ST_FIN : ST_CALC;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UMTS; i++) begin
        cfg_q[i]   <= '0;
        alloc_q[i] <= '0;
      end
      idx_q <= '0;  cols_q <= '0;  rows_q <= '0;
      pool_used_q[0] <= '0;  pool_used_q[1] <= '0;
      lmts_q <= '0;  pmts_q <= '0;
      drop_q <= 1'b0;  sram_ovf_q <= 1'b0;  tcam_ovf_q <= 1'b0;
      busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;  code_q <= ERR_NONE;
      total_lmts_q <= '0;  total_pmts_q <= '0;
      lkp_q <= '0;
    end else begin
      if (cfg_wr) begin
        if (idle) begin
          cfg_q[bus.umt_cfg_id] <= '{valid: (bus.umt_cfg_width != 16'd0) && (bus.umt_cfg_depth != 16'd0),
                                     ttype: bus.umt_cfg_type,
                                     width: bus.umt_cfg_width,
                                     depth: bus.umt_cfg_depth};
          done_q <= 1'b0;
        end else begin
          drop_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: if (bus.umt_map_trigger) begin
          idx_q <= '0;  lmts_q <= '0;  pmts_q <= '0;
          pool_used_q[0] <= '0;  pool_used_q[1] <= '0;
          drop_q <= 1'b0;  sram_ovf_q <= 1'b0;  tcam_ovf_q <= 1'b0;
          for (int i = 0; i < NUM_UMTS; i++) alloc_q[i] <= '0;
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end
        ST_CALC: begin
          if (cur_cfg.valid) begin
            cols_q <= calc_cols;
            rows_q <= calc_rows;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        ST_ACCUM: begin
          pmts_q <= pmts_next;
          if (fit) begin
            alloc_q[idx_q] <= '{valid: 1'b1, ttype: cur_cfg.ttype,
                                base: pool_used_q[cur_cfg.ttype], num: calc_num};
            // fit guarantees the sum stays within an 8-bit pool size.
            pool_used_q[cur_cfg.ttype] <= pool_used_q[cur_cfg.ttype] + calc_num[7:0];
            lmts_q <= lmts_q + 8'd1;
          end else begin
            alloc_q[idx_q] <= '0;
            if (cur_cfg.ttype) tcam_ovf_q <= 1'b1;
            else               sram_ovf_q <= 1'b1;
          end
          idx_q <= idx_q + 3'd1;
        end
        ST_FIN: begin
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          error_q      <= drop_now | sram_ovf_q | tcam_ovf_q;
          code_q       <= code_next;
          total_lmts_q <= lmts_q;
          total_pmts_q <= pmts_q;
        end
        default: ;
      endcase

      lkp_q <= alloc_q[bus.lkp_id];
    end
  end

  assign bus.map_busy          = busy_q;
  assign bus.map_done          = done_q;
  assign bus.map_error         = error_q;
  assign bus.map_err_code      = code_q;
  assign bus.total_lmts_used   = total_lmts_q;
  assign bus.total_pmts_needed = total_pmts_q;
  assign bus.lkp_valid         = lkp_q.valid;
  assign bus.lkp_type          = lkp_q.ttype;
  assign bus.lkp_base          = lkp_q.base;
  assign bus.lkp_num           = lkp_q.num;
  assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_umt_lmt_mapper.sv
// Directed bench for umt_lmt_mapper: drivers push hand-computed expectations,
// monitors pop them when map_done rises or a lookup result returns.
module tb_umt_lmt_mapper;
  import umt_pkg::*;

  logic clk;
  logic rst_n;
  umt_lmt_mapper_if bus();

  umt_lmt_mapper dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // status: {latency[7:0], error, code[1:0], lmts[7:0], pmts[15:0]}
  logic [34:0] exp_q[$];
  // lookup: {valid, type, base[7:0], num[15:0]}
  logic [25:0] lkp_exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int trig_cyc = 0;
  logic lkp_req   = 1'b0;
  logic lkp_req_d = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lkp_req_d <= lkp_req;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] mk_stat(input int lat, input logic err, input logic [1:0] code,
                                          input logic [7:0] lmts, input logic [15:0] pmts);
    return {8'(lat), err, code, lmts, pmts};
  endfunction

  function automatic logic [25:0] mk_lkp(input logic v, input logic t, input logic [7:0] b,
                                         input logic [15:0] n);
    return {v, t, b, n};
  endfunction

  // drivers
  task automatic cfg_write(input logic [2:0] id, input logic [15:0] w, input logic [15:0] d,
                           input logic t);
    bus.umt_cfg_valid = 1'b1;  bus.umt_cfg_wr_en = 1'b1;
    bus.umt_cfg_id = id;  bus.umt_cfg_width = w;  bus.umt_cfg_depth = d;  bus.umt_cfg_type = t;
    @(posedge clk); #1;
    bus.umt_cfg_valid = 1'b0;  bus.umt_cfg_wr_en = 1'b0;
  endtask

  task automatic trigger();
    bus.umt_map_trigger = 1'b1;
    @(posedge clk); #1;
    bus.umt_map_trigger = 1'b0;
    trig_cyc = cyc;
  endtask

  task automatic lookup(input logic [2:0] id, input logic [25:0] exp);
    bus.lkp_id = id;
    lkp_req = 1'b1;
    lkp_exp_q.push_back(exp);
    @(posedge clk); #1;
    lkp_req = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (bus.map_done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain_lookups();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard monitors
  initial begin
    logic prev_done;
    logic [34:0] e, a;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.map_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("status_unexpected", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          a = {8'(cyc - trig_cyc), bus.map_error, bus.map_err_code,
               bus.total_lmts_used, bus.total_pmts_needed};
          check("status", 64'(a), 64'(e));
        end
      end
      prev_done = bus.map_done;
    end
  end

  initial begin
    logic [25:0] e, a;
    forever begin
      @(negedge clk);
      if (rst_n && lkp_req_d) begin
        if (lkp_exp_q.size() == 0) begin
          check("lkp_unexpected", 64'd0, 64'd1);
        end else begin
          e = lkp_exp_q.pop_front();
          a = {bus.lkp_valid, bus.lkp_type, bus.lkp_base, bus.lkp_num};
          check("lkp", 64'(a), 64'(e));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.map_busy), 64'd0);
    check({tag, "_done"},  64'(bus.map_done), 64'd0);
    check({tag, "_error"}, 64'({bus.map_error, bus.map_err_code}), 64'd0);
    check({tag, "_totals"}, 64'({bus.total_lmts_used, bus.total_pmts_needed}), 64'd0);
    check({tag, "_lkp"},   64'({bus.lkp_valid, bus.lkp_type, bus.lkp_base, bus.lkp_num}), 64'd0);
    check({tag, "_state"}, 64'(bus.dbg_state), 64'(ST_IDLE));
  endtask

  // stimulus
  initial begin
    rst_n = 1'b0;
    bus.umt_cfg_valid = 1'b0;  bus.umt_cfg_wr_en = 1'b0;  bus.umt_cfg_id = '0;
    bus.umt_cfg_width = '0;  bus.umt_cfg_depth = '0;  bus.umt_cfg_type = 1'b0;
    bus.umt_map_trigger = 1'b0;  bus.lkp_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single 1x1 SRAM table
    cfg_write(3'd0, 16'd64, 16'd512, 1'b0);
    exp_q.push_back(mk_stat(10, 1'b0, ERR_NONE, 8'd1, 16'd1));
    trigger();
    wait_done(40);
    lookup(3'd0, mk_lkp(1'b1, 1'b0, 8'd0, 16'd1));
    drain_lookups();

    // rounding up on both axes, one table per pool
    cfg_write(3'd0, 16'd65, 16'd513, 1'b0);
    cfg_write(3'd1, 16'd128, 16'd1024, 1'b1);
    exp_q.push_back(mk_stat(11, 1'b0, ERR_NONE, 8'd2, 16'd8));
    trigger();
    wait_done(40);
    lookup(3'd0, mk_lkp(1'b1, 1'b0, 8'd0, 16'd4));
    lookup(3'd1, mk_lkp(1'b1, 1'b1, 8'd0, 16'd4));
    drain_lookups();

    // TCAM pool overflow; first write after done must clear map_done
    cfg_write(3'd0, 16'd160, 16'd1024, 1'b1);
    @(negedge clk);
    check("done_cleared_by_write", 64'(bus.map_done), 64'd0);
    @(posedge clk); #1;
    cfg_write(3'd1, 16'd160, 16'd1024, 1'b1);
    cfg_write(3'd2, 16'd160, 16'd1024, 1'b1);
    cfg_write(3'd3, 16'd160, 16'd1024, 1'b1);
    exp_q.push_back(mk_stat(13, 1'b1, ERR_TCAM_OVF, 8'd2, 16'd24));
    trigger();
    wait_done(40);
    lookup(3'd0, mk_lkp(1'b1, 1'b1, 8'd0, 16'd6));
    lookup(3'd1, mk_lkp(1'b1, 1'b1, 8'd6, 16'd6));
    lookup(3'd2, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    lookup(3'd3, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    drain_lookups();

    // write during scan is dropped and reported with top priority
    exp_q.push_back(mk_stat(13, 1'b1, ERR_CFG_DROP, 8'd2, 16'd24));
    trigger();
    cfg_write(3'd4, 16'd64, 16'd512, 1'b0);
    wait_done(40);
    lookup(3'd4, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    drain_lookups();

    // delete UMT1; error state holds across the write; retrigger mid-scan ignored
    cfg_write(3'd1, 16'd0, 16'd512, 1'b1);
    @(negedge clk);
    check("delete_write_done", 64'(bus.map_done), 64'd0);
    check("error_held", 64'({bus.map_error, bus.map_err_code}), 64'({1'b1, ERR_CFG_DROP}));
    @(posedge clk); #1;
    exp_q.push_back(mk_stat(12, 1'b1, ERR_TCAM_OVF, 8'd2, 16'd18));
    trigger();
    check("busy_after_trigger", 64'({bus.map_busy, bus.map_done}), 64'b10);
    repeat (3) @(posedge clk);
    #1;
    bus.umt_map_trigger = 1'b1;
    @(posedge clk); #1;
    bus.umt_map_trigger = 1'b0;
    wait_done(40);
    lookup(3'd1, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    lookup(3'd2, mk_lkp(1'b1, 1'b1, 8'd6, 16'd6));
    lookup(3'd3, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    drain_lookups();

    // SRAM overflow outranks TCAM overflow; PMT count and total saturate
    cfg_write(3'd5, 16'd4096, 16'd4096, 1'b0);
    cfg_write(3'd6, 16'd65535, 16'd65535, 1'b0);
    exp_q.push_back(mk_stat(14, 1'b1, ERR_SRAM_OVF, 8'd2, 16'hFFFF));
    trigger();
    wait_done(40);
    lookup(3'd5, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    lookup(3'd6, mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    lookup(3'd0, mk_lkp(1'b1, 1'b1, 8'd0, 16'd6));
    drain_lookups();

    // reset while in ACCUM for UMT0
    trigger();
    @(posedge clk); #1;
    check("pre_reset_state", 64'(bus.dbg_state), 64'(ST_ACCUM));
    rst_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) lookup(3'(i), mk_lkp(1'b0, 1'b0, 8'd0, 16'd0));
    drain_lookups();

    // empty config after reset: done after exactly 9 clocks, nothing allocated
    exp_q.push_back(mk_stat(9, 1'b0, ERR_NONE, 8'd0, 16'd0));
    trigger();
    wait_done(40);

    repeat (3) @(posedge clk);
    #1;
    check("status_queue_drained", 64'(exp_q.size()), 64'd0);
    check("lkp_queue_drained", 64'(lkp_exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
